cmd_frame_parser: RTL and testbench

CMD_FRAME_PARSER -- requirements
Module: cmd_frame_parser

---
 rtl/cmd_frame_parser_if.sv | 35 +++
 rtl/cmd_frame_parser.sv | 203 ++++++++++++++++++++
 tb/tb_cmd_frame_parser.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_frame_parser_if.sv
// Bundles the byte-stream input and the decoded command outputs of
// cmd_frame_parser. The parser attaches through the slave modport. The
// byte source and the command consumer attach through the master modport.
interface cmd_frame_parser_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic        frame_err;

  modport slave (
    input  rx_data,
    input  rx_valid,
    output wr_en,
    output wr_addr,
    output wr_data,
    output rd_en,
    output rd_addr,
    output frame_err
  );

  modport master (
    output rx_data,
    output rx_valid,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  rd_en,
    input  rd_addr,
    input  frame_err
  );
endinterface

// File: rtl/cmd_frame_parser.sv
// Command frame parser. It decodes the byte stream
//   0x55, CMD, ADDR[31:24..7:0], {DATA[15:8], DATA[7:0] for writes}, SUM
// into one-cycle write/read command pulses. Address and data are collected in
// shadow registers. The visible outputs change only when a frame arrives
// with a correct checksum. A bad command, a bad checksum or an inter-byte
// stall of TIMEOUT_CYCLES produces a one-cycle frame_err pulse.
module cmd_frame_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input logic               i_clk,
  input logic               i_reset,
  cmd_frame_parser_if.slave bus
);

  localparam int unsigned      TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]    TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       HDR     = 8'h55;
  localparam logic [7:0]       CMD_WR  = 8'h01;
  localparam logic [7:0]       CMD_RD  = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_SUM  = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic [1:0]     r_idx;
  logic           r_is_wr;
  logic [7:0]     r_sum;
  logic [31:0]    r_shadow_addr;
  logic [15:0]    r_shadow_data;
  logic [TW-1:0]  r_tcnt;

  logic           r_wr_en;
  logic           r_rd_en;
  logic           r_frame_err;
  logic [31:0]    r_wr_addr;
  logic [15:0]    r_wr_data;
  logic [31:0]    r_rd_addr;

  logic           w_timeout;
  logic           w_fire_wr;
  logic           w_fire_rd;
  logic           w_err;

  // Modulo-256 checksum accumulation. The carry is dropped on purpose.
  function automatic logic [7:0] sum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  // The timeout fires only on an idle cycle. A byte in the same cycle wins.
  assign w_timeout = (r_state != ST_IDLE) && !bus.rx_valid && (r_tcnt == TO_LAST);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode: advance on received bytes, abort on timeout
  always_comb begin
    w_next_state = r_state;
    if (w_timeout) begin
      w_next_state = ST_IDLE;
    end else if (bus.rx_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.rx_data == HDR) w_next_state = ST_CMD;
          else                    w_next_state = ST_IDLE;
        end
        ST_CMD: begin
          if ((bus.rx_data == CMD_WR) || (bus.rx_data == CMD_RD)) w_next_state = ST_ADDR;
          else                                                    w_next_state = ST_IDLE;
        end
        ST_ADDR: begin
          if (r_idx == 2'd3) w_next_state = r_is_wr ? ST_DATA : ST_SUM;
          else               w_next_state = ST_ADDR;
        end
        ST_DATA: begin
          if (r_idx == 2'd1) w_next_state = ST_SUM;
          else               w_next_state = ST_DATA;
        end
        ST_SUM:  w_next_state = ST_IDLE;
        default: w_next_state = ST_IDLE;
      endcase
    end else begin
      w_next_state = r_state;
    end
  end

  // Output decode: command fire on a good SUM, error on bad CMD/SUM/timeout
  always_comb begin
    w_fire_wr = 1'b0;
    w_fire_rd = 1'b0;
    w_err     = 1'b0;
    if (w_timeout) begin
      w_err = 1'b1;
    end else if (bus.rx_valid) begin
      case (r_state)
        ST_CMD: begin
          if ((bus.rx_data == CMD_WR) || (bus.rx_data == CMD_RD)) w_err = 1'b0;
          else                                                    w_err = 1'b1;
        end
        ST_SUM: begin
          if (bus.rx_data == r_sum) begin
            w_fire_wr = r_is_wr;
            w_fire_rd = !r_is_wr;
          end else begin
            w_err = 1'b1;
          end
        end
        default: w_err = 1'b0;
      endcase
    end else begin
      w_err = 1'b0;
    end
  end

  // Frame progress: byte index, command type, running checksum, shadow fields
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_idx         <= 2'd0;
      r_is_wr       <= 1'b0;
      r_sum         <= 8'h00;
      r_shadow_addr <= 32'h0000_0000;
      r_shadow_data <= 16'h0000;
    end else if (bus.rx_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.rx_data == HDR) begin
            r_sum <= 8'h00;
            r_idx <= 2'd0;
          end
        end
        ST_CMD: begin
          r_sum   <= sum_add(r_sum, bus.rx_data);
          r_is_wr <= (bus.rx_data == CMD_WR);
          r_idx   <= 2'd0;
        end
        ST_ADDR: begin
          r_sum         <= sum_add(r_sum, bus.rx_data);
          r_shadow_addr <= {r_shadow_addr[23:0], bus.rx_data};
          r_idx         <= (r_idx == 2'd3) ? 2'd0 : r_idx + 2'd1;
        end
        ST_DATA: begin
          r_sum         <= sum_add(r_sum, bus.rx_data);
          r_shadow_data <= {r_shadow_data[7:0], bus.rx_data};
          r_idx         <= r_idx + 2'd1;
        end
        default: r_idx <= r_idx;
      endcase
    end
  end

  // Inter-byte idle counter. It is held at zero in IDLE and on every received byte.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tcnt <= '0;
    end else if ((r_state == ST_IDLE) || bus.rx_valid || w_timeout) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= r_tcnt + TW'(1);
    end
  end

  // Registered outputs: one-cycle pulses, command fields updated only on a good frame
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_frame_err <= 1'b0;
      r_wr_addr   <= 32'h0000_0000;
      r_wr_data   <= 16'h0000;
      r_rd_addr   <= 32'h0000_0000;
    end else begin
      r_wr_en     <= w_fire_wr;
      r_rd_en     <= w_fire_rd;
      r_frame_err <= w_err;
      if (w_fire_wr) begin
        r_wr_addr <= r_shadow_addr;
        r_wr_data <= r_shadow_data;
      end
      if (w_fire_rd) begin
        r_rd_addr <= r_shadow_addr;
      end
    end
  end

  assign bus.wr_en     = r_wr_en;
  assign bus.rd_en     = r_rd_en;
  assign bus.frame_err = r_frame_err;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.rd_addr   = r_rd_addr;

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Scoreboard bench for cmd_frame_parser (TIMEOUT_CYCLES = 16).
// The stimulus pushes the expected pulse, the cycle it is due in and the
// output fields into a queue. The monitor pops an entry whenever the DUT
// pulses and compares it. An entry that stays past its due cycle counts as
// a missed pulse.
module tb_cmd_frame_parser;

  typedef struct {
    int          kind;   // 0 = write, 1 = read, 2 = frame error
    int          cyc;
    logic [31:0] wa;
    logic [15:0] wd;
    logic [31:0] ra;
  } ev_t;

  logic        clk;
  logic        reset;
  int          cyc;
  ev_t         sb[$];
  logic [7:0]  seq[$];
  logic [31:0] m_wa;
  logic [15:0] m_wd;
  logic [31:0] m_ra;
  int          zero_req;
  logic        done;
  int          n_vec;
  int          n_fail;

  cmd_frame_parser_if bus ();

  cmd_frame_parser #(.TIMEOUT_CYCLES(16)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus ----------------
  task automatic drive(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(input int kind, input int dly, input logic [31:0] a, input logic [15:0] d);
    ev_t e;
    if (kind == 0) begin
      m_wa = a;
      m_wd = d;
    end else if (kind == 1) begin
      m_ra = a;
    end
    e.kind = kind;
    e.cyc  = cyc + dly;
    e.wa   = m_wa;
    e.wd   = m_wd;
    e.ra   = m_ra;
    sb.push_back(e);
  endtask

  // Sends seq. Before byte ev_idx, it registers the response that byte should cause.
  task automatic send(input int ev_idx, input int kind, input logic [31:0] a, input logic [15:0] d);
    for (int i = 0; i < seq.size(); i++) begin
      if (i == ev_idx) expect_ev(kind, 1, a, d);
      drive(seq[i]);
    end
  endtask

  task automatic reset_and_check();
    reset = 1'b1;
    @(negedge clk);
    zero_req = zero_req + 1;
    idle(3);
    reset = 1'b0;
    m_wa = 32'h0;
    m_wd = 16'h0;
    m_ra = 32'h0;
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    reset    = 1'b1;
    zero_req = 0;
    done     = 1'b0;
    cyc      = 0;
    m_wa = 32'h0; m_wd = 16'h0; m_ra = 32'h0;
    @(negedge clk);
    reset_and_check();
    idle(2);

    // Valid write: 0x01+0x01+0x03+0x30 = 0x35
    seq = {8'h55, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h03, 8'h30, 8'h35};
    send(8, 0, 32'h0000_0001, 16'h0330);
    idle(3);

    // Back-to-back reads, addr 0 (sum 0x02) then addr 1 (sum 0x03)
    seq = {8'h55, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};
    send(6, 1, 32'h0, 16'h0);
    seq = {8'h55, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h03};
    send(6, 1, 32'h0000_0001, 16'h0);
    idle(3);

    // Wrong sums (correct is 0x35): error, write fields hold
    seq = {8'h55, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h03, 8'h30, 8'h37};
    send(8, 2, 32'h0, 16'h0);
    seq = {8'h55, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h03, 8'h30, 8'h36};
    send(8, 2, 32'h0, 16'h0);
    idle(2);

    // Write whose sum wraps: 01+12+34+56+78+AB+CD = 0x28D -> 0x8D
    seq = {8'h55, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'hAB, 8'hCD, 8'h8D};
    send(8, 0, 32'h1234_5678, 16'hABCD);
    idle(2);

    // Bad commands, then stray bytes in IDLE (no response)
    seq = {8'h55, 8'h07};
    send(1, 2, 32'h0, 16'h0);
    seq = {8'hAA, 8'h12};
    send(-1, 0, 32'h0, 16'h0);
    seq = {8'h55, 8'h03};
    send(1, 2, 32'h0, 16'h0);
    idle(3);

    // Stall of 16 idle cycles: timeout error on the 16th
    seq = {8'h55, 8'h01, 8'h00};
    send(-1, 0, 32'h0, 16'h0);
    expect_ev(2, 16, 32'h0, 16'h0);
    idle(20);
    seq = {8'h55, 8'h02, 8'h00, 8'h00, 8'h00, 8'h09, 8'h0B};
    send(6, 1, 32'h0000_0009, 16'h0);
    idle(2);

    // Stall of 15 idle cycles: frame still completes (01+02+07 = 0x0A)
    seq = {8'h55, 8'h01, 8'h00};
    send(-1, 0, 32'h0, 16'h0);
    idle(15);
    seq = {8'h00, 8'h00, 8'h02, 8'h00, 8'h07, 8'h0A};
    send(5, 0, 32'h0000_0002, 16'h0007);
    idle(2);

    // Reset mid-frame with a header byte presented during reset
    seq = {8'h55, 8'h01, 8'h00, 8'h00};
    send(-1, 0, 32'h0, 16'h0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h55;
    reset_and_check();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    // Headerless read body: must all be dropped
    seq = {8'h02, 8'h00, 8'h00, 8'h00, 8'h05, 8'h07};
    send(-1, 0, 32'h0, 16'h0);
    // 01+AB+CD+00+01+02+03 = 0x17F -> 0x7F
    seq = {8'h55, 8'h01, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'h02, 8'h03, 8'h7F};
    send(8, 0, 32'hABCD_0001, 16'h0203);
    idle(5);
    done = 1'b1;
  end

  // ---------------- monitor ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_vec = n_vec + 1;
    if (act !== exp_v) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  initial begin
    ev_t e;
    int  seen_zero;
    n_vec     = 0;
    n_fail    = 0;
    seen_zero = 0;
    forever begin
      @(negedge clk);
      if (seen_zero != zero_req) begin
        seen_zero = zero_req;
        chk("reset_wr_en",     {63'h0, bus.wr_en},     64'h0);
        chk("reset_rd_en",     {63'h0, bus.rd_en},     64'h0);
        chk("reset_frame_err", {63'h0, bus.frame_err}, 64'h0);
        chk("reset_wr_addr",   {32'h0, bus.wr_addr},   64'h0);
        chk("reset_wr_data",   {48'h0, bus.wr_data},   64'h0);
        chk("reset_rd_addr",   {32'h0, bus.rd_addr},   64'h0);
      end
      if (bus.wr_en || bus.rd_en || bus.frame_err) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {61'h0, bus.wr_en, bus.rd_en, bus.frame_err}, 64'h0);
        end else begin
          e = sb.pop_front();
          chk("pulse_cycle", 64'(cyc),            64'(e.cyc));
          chk("wr_en",       {63'h0, bus.wr_en},     {63'h0, e.kind == 0});
          chk("rd_en",       {63'h0, bus.rd_en},     {63'h0, e.kind == 1});
          chk("frame_err",   {63'h0, bus.frame_err}, {63'h0, e.kind == 2});
          chk("wr_addr",     {32'h0, bus.wr_addr},   {32'h0, e.wa});
          chk("wr_data",     {48'h0, bus.wr_data},   {48'h0, e.wd});
          chk("rd_addr",     {32'h0, bus.rd_addr},   {32'h0, e.ra});
        end
      end else if ((sb.size() != 0) && (sb[0].cyc < cyc)) begin
        e = sb.pop_front();
        chk("missing_pulse_kind", 64'hFF, 64'(e.kind));
      end
      if (done || (cyc > 20000)) begin
        chk("unconsumed_expectations", 64'(sb.size()), 64'h0);
        chk("run_completed", {63'h0, done}, 64'h1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
      end
    end
  end

endmodule
